// File: rtl/colour_pkg.sv
// Shared encodings and helpers for the colour mixer pixel stage.
package colour_pkg;

  localparam logic [1:0] ST_START = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_WIN   = 2'b10;
  localparam logic [1:0] ST_LOSE  = 2'b11;

  localparam logic [3:0] LVL_MAX = 4'd15;

  typedef enum logic {
    FADE_IDLE = 1'b0,
    FADE_RUN  = 1'b1
  } fade_state_e;

  // Bits per colour channel for a packed RGB word.
  function automatic int unsigned ch_width(input int unsigned col_w);
    return col_w / 3;
  endfunction

endpackage

// File: rtl/channel_scaler.sv
// Scales one colour channel by (level+1)/16; level 15 passes the channel through.
module channel_scaler #(
  parameter int unsigned CH_W = 4
) (
  input  logic [CH_W-1:0] ch,
  input  logic [3:0]      level,
  output logic [CH_W-1:0] scaled_c
);

  localparam int unsigned P_W = CH_W + 5;

  logic [4:0]     mult_c;
  logic [P_W-1:0] prod_c;

  always_comb begin
    mult_c   = {1'b0, level} + 5'd1;
    prod_c   = P_W'(ch) * P_W'(mult_c);
    scaled_c = CH_W'(prod_c >> 4);
  end

endmodule

// File: rtl/colour_mixer.sv
// Pixel colour stage: per-state colour select, fade-in on state change,
// frame counter and a fixed two-register pipeline to COLOUR_OUT.
module colour_mixer
  import colour_pkg::*;
#(
  parameter int unsigned    COL_W        = 12,
  parameter int unsigned    V_W          = 9,
  parameter int unsigned    H_W          = 10,
  parameter int unsigned    V_MAX        = 479,
  parameter int unsigned    H_MAX        = 639,
  parameter int unsigned    V_CENTRE     = 240,
  parameter int unsigned    H_CENTRE     = 320,
  parameter int unsigned    FRAME_W      = 16,
  parameter int unsigned    FADE_SHIFT   = 2,
  parameter int unsigned    BLINK_BIT    = 4,
  parameter logic [COL_W-1:0] START_COLOUR = 12'hF00
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [V_W-1:0]   VERT_ADDR,
  input  logic [H_W-1:0]   HORZ_ADDR,
  input  logic [COL_W-1:0] COLOUR_IN,
  input  logic [1:0]       M_STATE,
  output logic [COL_W-1:0] COLOUR_OUT,
  output logic             FADE_BUSY
);

  localparam int unsigned CH_W = ch_width(COL_W);
  localparam int unsigned D_W  = ((V_W > H_W) ? V_W : H_W) + 1;
  localparam int unsigned S_W  = (FADE_SHIFT > 0) ? FADE_SHIFT : 1;
  localparam logic [S_W-1:0] STEP_MAX = S_W'((1 << FADE_SHIFT) - 1);

  logic               frame_tick_c;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [COL_W-1:0]   sel_col_q, sel_col_d;
  logic [COL_W-1:0]   colour_out_q, colour_out_d;
  logic [COL_W-1:0]   scaled_c;
  logic [COL_W-1:0]   anim_c;
  logic [D_W-1:0]     v_ext_c, h_ext_c, vc_ext_c, hc_ext_c, dv_c, dh_c;
  logic [1:0]         prev_state_q, prev_state_d;
  logic [3:0]         level_q, level_d;
  logic [S_W-1:0]     step_q, step_d;
  fade_state_e        fade_state_q, fade_state_d;
  logic               fade_busy_q, fade_busy_d;

  // One tick per frame, on the last visible pixel.
  always_comb begin
    frame_tick_c = (VERT_ADDR == V_W'(V_MAX)) && (HORZ_ADDR == H_W'(H_MAX));
    frame_cnt_d  = frame_cnt_q + FRAME_W'(frame_tick_c);
  end

  // Win animation: diamond rings radiating from the centre, drifting with frame count.
  always_comb begin
    v_ext_c  = D_W'(VERT_ADDR);
    h_ext_c  = D_W'(HORZ_ADDR);
    vc_ext_c = D_W'(V_CENTRE);
    hc_ext_c = D_W'(H_CENTRE);
    dv_c     = (v_ext_c >= vc_ext_c) ? (v_ext_c - vc_ext_c) : (vc_ext_c - v_ext_c);
    dh_c     = (h_ext_c >= hc_ext_c) ? (h_ext_c - hc_ext_c) : (hc_ext_c - h_ext_c);
    anim_c   = COL_W'(frame_cnt_q[FRAME_W-1 -: 8]) + COL_W'(dv_c) + COL_W'(dh_c);
  end

  // Stage 1 select.
  always_comb begin
    sel_col_d = COLOUR_IN;
    case (M_STATE)
      ST_START: sel_col_d = START_COLOUR;
      ST_PLAY:  sel_col_d = COLOUR_IN;
      ST_WIN:   sel_col_d = anim_c;
      default:  sel_col_d = frame_cnt_q[BLINK_BIT] ? ~COLOUR_IN : COLOUR_IN;
    endcase
  end

  // Fade FSM; a state change always restarts from level 0, even on a tick.
  always_comb begin
    fade_state_d = fade_state_q;
    level_d      = level_q;
    step_d       = step_q;
    prev_state_d = M_STATE;
    if (M_STATE != prev_state_q) begin
      level_d      = 4'd0;
      step_d       = '0;
      fade_state_d = FADE_RUN;
    end else if (frame_tick_c && (level_q < LVL_MAX)) begin
      if (step_q == STEP_MAX) begin
        step_d  = '0;
        level_d = level_q + 4'd1;
        if (level_q == (LVL_MAX - 4'd1)) begin
          fade_state_d = FADE_IDLE;
        end
      end else begin
        step_d = step_q + S_W'(1);
      end
    end
    fade_busy_d = (fade_state_d == FADE_RUN);
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    channel_scaler #(
      .CH_W(CH_W)
    ) u_scaler (
      .ch       (sel_col_q[g*CH_W +: CH_W]),
      .level    (level_q),
      .scaled_c (scaled_c[g*CH_W +: CH_W])
    );
  end

  always_comb begin
    colour_out_d = scaled_c;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_cnt_q  <= '0;
      sel_col_q    <= '0;
      colour_out_q <= '0;
      prev_state_q <= ST_START;
      level_q      <= LVL_MAX;
      step_q       <= '0;
      fade_state_q <= FADE_IDLE;
      fade_busy_q  <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      sel_col_q    <= sel_col_d;
      colour_out_q <= colour_out_d;
      prev_state_q <= prev_state_d;
      level_q      <= level_d;
      step_q       <= step_d;
      fade_state_q <= fade_state_d;
      fade_busy_q  <= fade_busy_d;
    end
  end

  assign COLOUR_OUT = colour_out_q;
  assign FADE_BUSY  = fade_busy_q;

endmodule

// File: tb/tb_colour_mixer.sv
// Directed testbench for colour_mixer with default parameters.
module tb_colour_mixer;

  logic        clk;
  logic        rst;
  logic [8:0]  v;
  logic [9:0]  h;
  logic [11:0] cin;
  logic [1:0]  ms;
  logic [11:0] cout;
  logic        busy;

  logic [15:0] fc;
  int tests;
  int failed;

  colour_mixer dut (
    .CLK        (clk),
    .RESET      (rst),
    .VERT_ADDR  (v),
    .HORZ_ADDR  (h),
    .COLOUR_IN  (cin),
    .M_STATE    (ms),
    .COLOUR_OUT (cout),
    .FADE_BUSY  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; tracks the expected frame count from the applied inputs.
  task automatic cyc();
    if (rst) fc = 16'd0;
    else if (v == 9'd479 && h == 10'd639) fc = fc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    v = 9'd479;
    h = 10'd639;
    for (int i = 0; i < n; i++) cyc();
    v = 9'd0;
    h = 10'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ms  = 2'b00;
    cin = 12'h000;
    repeat (3) cyc();
    tests++;
    if (cout !== 12'h000) begin
      failed++;
      $display("FAIL reset_colour: got %h expected %h", cout, 12'h000);
    end
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    rst = 1'b0;
    cyc();
    cyc();
    tests++;
    if (cout !== 12'hF00) begin
      failed++;
      $display("FAIL reset_start_colour: got %h expected %h", cout, 12'hF00);
    end
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_no_fade: got %b expected 0", busy);
    end
  endtask

  task automatic test_play();
    logic [11:0] vals [6];
    logic [11:0] prev;
    vals[0] = 12'h123; vals[1] = 12'hABC; vals[2] = 12'hFFF;
    vals[3] = 12'h000; vals[4] = 12'h5A5; vals[5] = 12'h3C7;
    ms  = 2'b01;
    cin = 12'h000;
    cyc();
    ticks(60);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL play_settled_busy: got %b expected 0", busy);
    end
    cin = 12'h5A3;
    cyc();
    cyc();
    tests++;
    if (cout !== 12'h5A3) begin
      failed++;
      $display("FAIL play_passthrough: got %h expected %h", cout, 12'h5A3);
    end
    prev = 12'h5A3;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) cin = vals[i];
      cyc();
      tests++;
      if (cout !== prev) begin
        failed++;
        $display("FAIL play_latency[%0d]: got %h expected %h", i, cout, prev);
      end
      if (i < 6) prev = vals[i];
    end
  endtask

  task automatic test_fade_ramp();
    ms = 2'b00;
    cyc();
    cin = 12'hFFF;
    ms  = 2'b01;
    cyc();
    cyc();
    tests++;
    if (cout !== 12'h000) begin
      failed++;
      $display("FAIL fade_first_pixel: got %h expected %h", cout, 12'h000);
    end
    tests++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL fade_busy_start: got %b expected 1", busy);
    end
    ticks(3);
    cyc();
    tests++;
    if (cout !== 12'h000) begin
      failed++;
      $display("FAIL fade_3_ticks: got %h expected %h", cout, 12'h000);
    end
    ticks(1);
    cyc();
    tests++;
    if (cout !== 12'h111) begin
      failed++;
      $display("FAIL fade_4_ticks: got %h expected %h", cout, 12'h111);
    end
    ticks(55);
    cyc();
    tests++;
    if (cout !== 12'hEEE || busy !== 1'b1) begin
      failed++;
      $display("FAIL fade_59_ticks: got %h/%b expected %h/1", cout, busy, 12'hEEE);
    end
    ticks(1);
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL fade_busy_end: got %b expected 0", busy);
    end
    cyc();
    tests++;
    if (cout !== 12'hFFF) begin
      failed++;
      $display("FAIL fade_60_ticks: got %h expected %h", cout, 12'hFFF);
    end
  endtask

  task automatic test_simultaneous();
    ms  = 2'b00;
    cin = 12'hFFF;
    cyc();
    ticks(6);
    ms = 2'b01;
    v  = 9'd479;
    h  = 10'd639;
    cyc();
    v = 9'd0;
    h = 10'd0;
    cyc();
    tests++;
    if (cout !== 12'h000 || busy !== 1'b1) begin
      failed++;
      $display("FAIL simul_level_reset: got %h/%b expected %h/1", cout, busy, 12'h000);
    end
    ticks(3);
    cyc();
    tests++;
    if (cout !== 12'h000) begin
      failed++;
      $display("FAIL simul_step_reset: got %h expected %h", cout, 12'h000);
    end
    ticks(1);
    cyc();
    tests++;
    if (cout !== 12'h111) begin
      failed++;
      $display("FAIL simul_level_one: got %h expected %h", cout, 12'h111);
    end
  endtask

  task automatic test_win();
    logic [8:0]  pv [4];
    logic [9:0]  ph [4];
    logic [11:0] pe [4];
    pv[0] = 9'd240; ph[0] = 10'd320; pe[0] = 12'h003;
    pv[1] = 9'd250; ph[1] = 10'd330; pe[1] = 12'h017;
    pv[2] = 9'd230; ph[2] = 10'd310; pe[2] = 12'h017;
    pv[3] = 9'd0;   ph[3] = 10'd0;   pe[3] = 12'h233;
    ms = 2'b10;
    cyc();
    ticks(int'(16'h0300 - fc));
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL win_busy: got %b expected 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      v = pv[i];
      h = ph[i];
      cyc();
      cyc();
      tests++;
      if (cout !== pe[i]) begin
        failed++;
        $display("FAIL win_anim[%0d]: got %h expected %h", i, cout, pe[i]);
      end
    end
    v = 9'd0;
    h = 10'd0;
  endtask

  task automatic test_lose_wrap();
    logic [11:0] exp;
    ms  = 2'b11;
    cin = 12'h0F0;
    cyc();
    ticks(60);
    ticks(int'(16'h0340 - fc));
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL lose_busy: got %b expected 0", busy);
    end
    for (int i = 0; i < 32; i++) begin
      exp = (i < 16) ? 12'h0F0 : 12'hF0F;
      cyc();
      cyc();
      tests++;
      if (cout !== exp) begin
        failed++;
        $display("FAIL lose_blink[%0d]: got %h expected %h", i, cout, exp);
      end
      ticks(1);
    end
    ticks(int'(16'hFFFF - fc));
    cyc();
    cyc();
    tests++;
    if (cout !== 12'hF0F) begin
      failed++;
      $display("FAIL lose_at_ffff: got %h expected %h", cout, 12'hF0F);
    end
    ticks(1);
    cyc();
    cyc();
    tests++;
    if (cout !== 12'h0F0) begin
      failed++;
      $display("FAIL lose_wrap: got %h expected %h", cout, 12'h0F0);
    end
  endtask

  task automatic test_reset_midfade();
    ms  = 2'b01;
    cin = 12'h777;
    cyc();
    ticks(5);
    rst = 1'b1;
    ms  = 2'b00;
    cyc();
    tests++;
    if (cout !== 12'h000 || busy !== 1'b0) begin
      failed++;
      $display("FAIL midfade_reset: got %h/%b expected %h/0", cout, busy, 12'h000);
    end
    rst = 1'b0;
    cyc();
    cyc();
    tests++;
    if (cout !== 12'hF00 || busy !== 1'b0) begin
      failed++;
      $display("FAIL midfade_release: got %h/%b expected %h/0", cout, busy, 12'hF00);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    fc     = 16'd0;
    rst    = 1'b1;
    v      = 9'd0;
    h      = 10'd0;
    cin    = 12'h000;
    ms     = 2'b00;
    test_reset();
    test_play();
    test_fade_ramp();
    test_simultaneous();
    test_win();
    test_lose_wrap();
    test_reset_midfade();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
